// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank multi-channel clock divider.
package clk_div_pkg;

   localparam int unsigned DIV_W_DEF = 8;

   typedef enum logic [1:0] {
      CH_IDLE,
      CH_LOW,
      CH_HIGH
   } ch_state_e;

   // Channel-select width; a single channel still needs a 1-bit select.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, registered toggle output, shadow divisor with load on
// falling boundaries. The align input exists only when CLK_DIV_BANK_ALIGN_EN is defined.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W   = DIV_W_DEF,
   parameter int unsigned DIV_RST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
`ifdef CLK_DIV_BANK_ALIGN_EN
   input  logic             align,
`endif
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             pending,
   output logic             upd_done,
   output logic             active,
   output logic             bclock
);

   ch_state_e        state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic             bclock_q, bclock_d;
   logic             upd_done_q;

   logic at_top;
   logic fall;
   logic align_hit;
   logic load;

`ifdef CLK_DIV_BANK_ALIGN_EN
   assign align_hit = align && (state_q != CH_IDLE);
`else
   assign align_hit = 1'b0;
`endif

   assign at_top = (cnt_q == div_q);
   assign fall   = (state_q == CH_HIGH) && at_top;
   // Divisor changes only where no phase can be shortened: idle, a falling edge, or align.
   assign load   = pending_q && ((state_q == CH_IDLE) || fall || align_hit);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bclock_d  = bclock_q;
      div_d     = div_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;

      unique case (state_q)
         CH_IDLE: begin
            cnt_d    = '0;
            bclock_d = 1'b0;
            if (en) state_d = CH_LOW;
         end
         CH_LOW: begin
            if (at_top) begin
               state_d  = CH_HIGH;
               bclock_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         CH_HIGH: begin
            if (at_top) begin
               state_d  = en ? CH_LOW : CH_IDLE;
               bclock_d = 1'b0;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: begin
            state_d  = CH_IDLE;
            bclock_d = 1'b0;
            cnt_d    = '0;
         end
      endcase

      if (align_hit) begin
         state_d  = en ? CH_LOW : CH_IDLE;
         bclock_d = 1'b0;
         cnt_d    = '0;
      end

      if (load) begin
         div_d     = shadow_q;
         pending_d = 1'b0;
      end

      if (wr) begin
         shadow_d  = wr_div;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CH_IDLE;
         cnt_q      <= '0;
         div_q      <= DIV_W'(DIV_RST);
         shadow_q   <= DIV_W'(DIV_RST);
         pending_q  <= 1'b0;
         bclock_q   <= 1'b0;
         upd_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         shadow_q   <= shadow_d;
         pending_q  <= pending_d;
         bclock_q   <= bclock_d;
         upd_done_q <= load;
      end
   end

   assign pending  = pending_q;
   assign upd_done = upd_done_q;
   assign active   = (state_q != CH_IDLE);
   assign bclock   = bclock_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider with valid/ready divisor updates.
// Define CLK_DIV_BANK_ALIGN_EN to add the align input for phase alignment.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned DIV_W   = DIV_W_DEF,
   parameter int unsigned DIV_RST = 1
) (
   input  logic                    pclock,
   input  logic                    prst_n,
   input  logic [NUM_CH-1:0]       ch_en,
`ifdef CLK_DIV_BANK_ALIGN_EN
   input  logic                    align,
`endif
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [ch_w(NUM_CH)-1:0] cfg_ch,
   input  logic [DIV_W-1:0]        cfg_div,
   output logic [NUM_CH-1:0]       upd_done,
   output logic [NUM_CH-1:0]       active,
   output logic [NUM_CH-1:0]       bclock
);

   localparam int unsigned CH_W = ch_w(NUM_CH);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] wr;

   // Out-of-range selects match no channel: ready stays high and the write is dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
      end
   end

   always_comb begin
      wr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_chan #(
         .DIV_W  (DIV_W),
         .DIV_RST(DIV_RST)
      ) u_chan (
         .clk     (pclock),
         .rst_n   (prst_n),
         .en      (ch_en[g]),
`ifdef CLK_DIV_BANK_ALIGN_EN
         .align   (align),
`endif
         .wr      (wr[g]),
         .wr_div  (cfg_div),
         .pending (pending[g]),
         .upd_done(upd_done[g]),
         .active  (active[g]),
         .bclock  (bclock[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: table-driven channel runs, upd_done scoreboard,
// and hand-written sequences for update, stop, reset and (optionally) align corners.
module tb_clk_div_bank;

   logic       pclock = 1'b0;
   logic       prst_n;
   logic [3:0] ch_en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [3:0] upd_done;
   logic [3:0] active;
   logic [3:0] bclock;

   // Three-channel instance: a 2-bit select can address a channel that does not exist.
   logic [2:0] o_ch_en;
   logic       o_cfg_valid;
   logic       o_cfg_ready;
   logic [1:0] o_cfg_ch;
   logic [7:0] o_cfg_div;
   logic [2:0] o_upd_done;
   logic [2:0] o_active;
   logic [2:0] o_bclock;
   logic       o_upd_seen = 1'b0;

`ifdef CLK_DIV_BANK_ALIGN_EN
   logic align;
`endif

   int checks   = 0;
   int failures = 0;
   int sb[$];

   typedef struct {
      int ch;
      int div;
      int exp_cyc;
   } vec_t;
   vec_t vecs[4];

   clk_div_bank #(.NUM_CH(4), .DIV_W(8), .DIV_RST(1)) u_dut (
      .pclock   (pclock),
      .prst_n   (prst_n),
      .ch_en    (ch_en),
`ifdef CLK_DIV_BANK_ALIGN_EN
      .align    (align),
`endif
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .upd_done (upd_done),
      .active   (active),
      .bclock   (bclock)
   );

   clk_div_bank #(.NUM_CH(3), .DIV_W(8), .DIV_RST(1)) u_dut_oob (
      .pclock   (pclock),
      .prst_n   (prst_n),
      .ch_en    (o_ch_en),
`ifdef CLK_DIV_BANK_ALIGN_EN
      .align    (align),
`endif
      .cfg_valid(o_cfg_valid),
      .cfg_ready(o_cfg_ready),
      .cfg_ch   (o_cfg_ch),
      .cfg_div  (o_cfg_div),
      .upd_done (o_upd_done),
      .active   (o_active),
      .bclock   (o_bclock)
   );

   always #5 pclock = ~pclock;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclock);
      #1;
   endtask

   task automatic count_until(input bit alt, input int ch, input logic val, input int limit,
                              output int n);
      n = 0;
      while (((alt ? o_bclock[ch] : bclock[ch]) !== val) && (n < limit)) begin
         step();
         n++;
      end
   endtask

   task automatic wr_cfg(input int ch, input int div, input logic exp_ready);
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = 8'(div);
      #1;
      check($sformatf("cfg_ready ch%0d", ch), cfg_ready, exp_ready);
      step();
      if (exp_ready) sb.push_back(ch);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_idle(input int ch, input int limit, input string name);
      int n;
      n = 0;
      while ((active[ch] !== 1'b0) && (n < limit)) begin
         step();
         n++;
      end
      check({name, "_active"}, active[ch], 0);
      check({name, "_bclock"}, bclock[ch], 0);
   endtask

   // Every upd_done pulse must retire exactly one accepted transfer to that channel.
   always begin
      int idx;
      @(posedge pclock);
      #2;
      if (prst_n === 1'b1) begin
         for (int i = 0; i < 4; i++) begin
            if (upd_done[i] === 1'b1) begin
               idx = -1;
               foreach (sb[j]) if (idx < 0 && sb[j] == i) idx = j;
               checks++;
               if (idx < 0) begin
                  failures++;
                  $display("FAIL upd_done_sb ch%0d: got pulse required none", i);
               end else begin
                  sb.delete(idx);
               end
            end
         end
         if (o_upd_done !== 3'b000) o_upd_seen = 1'b1;
      end
   end

   initial begin
      int   n;
      int   r0;
      int   r1;
      logic bad;

      vecs[0] = '{ch: 0, div: 1,   exp_cyc: 2};
      vecs[1] = '{ch: 1, div: 0,   exp_cyc: 1};
      vecs[2] = '{ch: 2, div: 2,   exp_cyc: 3};
      vecs[3] = '{ch: 3, div: 255, exp_cyc: 256};

      prst_n      = 1'b0;
      ch_en       = '0;
      cfg_valid   = 1'b0;
      cfg_ch      = '0;
      cfg_div     = '0;
      o_ch_en     = '0;
      o_cfg_valid = 1'b0;
      o_cfg_ch    = '0;
      o_cfg_div   = '0;
`ifdef CLK_DIV_BANK_ALIGN_EN
      align       = 1'b0;
`endif

      #12;
      check("rst_bclock", bclock, 0);
      check("rst_active", active, 0);
      check("rst_upd_done", upd_done, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      @(negedge pclock);
      prst_n = 1'b1;
      step();
      check("post_rst_active", active, 0);

      // Table: program, start, measure both phases, stop mid-high.
      for (int v = 0; v < 4; v++) begin
         wr_cfg(vecs[v].ch, vecs[v].div, 1'b1);
         step();
         ch_en[vecs[v].ch] = 1'b1;
         step();
         check($sformatf("start_active ch%0d", vecs[v].ch), active[vecs[v].ch], 1);
         count_until(1'b0, vecs[v].ch, 1'b1, 600, n);
         check($sformatf("start_lat ch%0d", vecs[v].ch), n, vecs[v].exp_cyc);
         count_until(1'b0, vecs[v].ch, 1'b0, 600, n);
         check($sformatf("high_w ch%0d", vecs[v].ch), n, vecs[v].exp_cyc);
         count_until(1'b0, vecs[v].ch, 1'b1, 600, n);
         check($sformatf("low_w ch%0d", vecs[v].ch), n, vecs[v].exp_cyc);
         ch_en[vecs[v].ch] = 1'b0;
         count_until(1'b0, vecs[v].ch, 1'b0, 600, n);
         check($sformatf("stop_high_w ch%0d", vecs[v].ch), n, vecs[v].exp_cyc);
         check($sformatf("stop_active ch%0d", vecs[v].ch), active[vecs[v].ch], 0);
         bad = 1'b0;
         for (int k = 0; k < vecs[v].div + 2; k++) begin
            step();
            if (bclock[vecs[v].ch] !== 1'b0 || active[vecs[v].ch] !== 1'b0) bad = 1'b1;
         end
         check($sformatf("stop_hold ch%0d", vecs[v].ch), bad, 0);
      end

      // Ch0 d=1 -> 3 written mid-high; load at the falling edge; ch1 writable meanwhile.
      ch_en[0] = 1'b1;
      step();
      count_until(1'b0, 0, 1'b1, 20, n);
      check("t2_lat", n, 2);
      wr_cfg(0, 3, 1'b1);
      check("t2_still_high", bclock[0], 1);
      check("t2_ready_blocked", cfg_ready, 0);
      cfg_valid = 1'b1;
      cfg_ch    = 2'd1;
      cfg_div   = 8'd2;
      #1;
      check("t2_ready_other", cfg_ready, 1);
      step();
      sb.push_back(1);
      cfg_valid = 1'b0;
      check("t2_fall", bclock[0], 0);
      check("t2_upd_done", upd_done, 4'b0001);
      count_until(1'b0, 0, 1'b1, 20, n);
      check("t2_low_new", n, 4);
      count_until(1'b0, 0, 1'b0, 20, n);
      check("t2_high_new", n, 4);
      ch_en[0] = 1'b0;
      wait_idle(0, 20, "t2_idle");

      // Ch1 d=2: drop enable one cycle into high, then restart.
      ch_en[1] = 1'b1;
      step();
      count_until(1'b0, 1, 1'b1, 20, n);
      check("t3_lat", n, 3);
      step();
      ch_en[1] = 1'b0;
      count_until(1'b0, 1, 1'b0, 20, n);
      check("t3_high_rest", n, 2);
      check("t3_active", active[1], 0);
      ch_en[1] = 1'b1;
      step();
      check("t3_reactive", active[1], 1);
      count_until(1'b0, 1, 1'b1, 20, n);
      check("t3_relat", n, 3);
      ch_en[1] = 1'b0;
      wait_idle(1, 20, "t3_idle");

      // Ch2 d=2: load and stop on the same falling boundary; second write refused.
      ch_en[2] = 1'b1;
      step();
      count_until(1'b0, 2, 1'b1, 20, n);
      check("ls_lat", n, 3);
      ch_en[2] = 1'b0;
      wr_cfg(2, 0, 1'b1);
      cfg_valid = 1'b1;
      cfg_ch    = 2'd2;
      cfg_div   = 8'd9;
      #1;
      check("ls_blocked", cfg_ready, 0);
      step();
      cfg_valid = 1'b0;
      check("ls_high", bclock[2], 1);
      step();
      check("ls_fall", bclock[2], 0);
      check("ls_active", active[2], 0);
      check("ls_upd_done", upd_done, 4'b0100);
      ch_en[2] = 1'b1;
      step();
      count_until(1'b0, 2, 1'b1, 10, n);
      check("ls_new_lat", n, 1);
      count_until(1'b0, 2, 1'b0, 10, n);
      check("ls_new_high", n, 1);
      ch_en[2] = 1'b0;
      wait_idle(2, 10, "ls_idle");

      // Out-of-range select on the three-channel instance.
      o_ch_en[0] = 1'b1;
      step();
      count_until(1'b1, 0, 1'b1, 20, n);
      check("oob_lat", n, 2);
      o_cfg_valid = 1'b1;
      o_cfg_ch    = 2'd3;
      o_cfg_div   = 8'd5;
      #1;
      check("oob_ready", o_cfg_ready, 1);
      step();
      o_cfg_valid = 1'b0;
      count_until(1'b1, 0, 1'b0, 20, n);
      check("oob_high_rest", n, 1);
      count_until(1'b1, 0, 1'b1, 20, n);
      check("oob_low", n, 2);
      count_until(1'b1, 0, 1'b0, 20, n);
      check("oob_high", n, 2);
      o_ch_en[0] = 1'b0;
      repeat (6) step();
      check("oob_active", o_active, 0);
      check("oob_no_upd", o_upd_seen, 0);

      // Asynchronous reset with all channels running and ch3 holding a pending update.
      ch_en = 4'hF;
      step();
      wr_cfg(3, 7, 1'b1);
      count_until(1'b0, 0, 1'b1, 20, n);
      check("rst5_pre_high", bclock[0], 1);
      #3;
      prst_n = 1'b0;
      #1;
      check("rst5_bclock", bclock, 0);
      check("rst5_active", active, 0);
      sb.delete();
      ch_en = '0;
      @(negedge pclock);
      @(negedge pclock);
      prst_n = 1'b1;
      step();
      cfg_ch = 2'd3;
      #1;
      check("rst5_ready", cfg_ready, 1);
      ch_en = 4'b1001;
      step();
      count_until(1'b0, 0, 1'b1, 20, n);
      check("rst5_lat0", n, 2);
      check("rst5_ch3_high", bclock[3], 1);
      ch_en = '0;
      wait_idle(0, 20, "rst5_idle0");
      wait_idle(3, 20, "rst5_idle3");

`ifdef CLK_DIV_BANK_ALIGN_EN
      wr_cfg(1, 2, 1'b1);
      step();
      ch_en = 4'b0011;
      repeat (5) step();
      align = 1'b1;
      step();
      align = 1'b0;
      check("al_low", bclock[1:0], 0);
      check("al_active", active[1:0], 3);
      r0 = 0;
      r1 = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (r0 == 0 && bclock[0] === 1'b1) r0 = k;
         if (r1 == 0 && bclock[1] === 1'b1) r1 = k;
      end
      check("al_rise0", r0, 2);
      check("al_rise1", r1, 3);
      ch_en = '0;
      wait_idle(0, 20, "al_idle0");
      wait_idle(1, 20, "al_idle1");
`else
      r0 = 0;
      r1 = 0;
`endif

      repeat (4) step();
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
